// File: rtl/decode_pkg.sv
// Shared types and constants for the 3-wide RV32I decode stage.
package decode_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int LANES      = 3;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // One decoded micro-op as handed to rename/issue.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] imm;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [2:0]            funct3;
    logic                  funct7b5;
    logic [6:0]            opcode;
    logic                  is_alu;
    logic                  is_branch;
    logic                  is_jal;
    logic                  is_jalr;
    logic                  is_load;
    logic                  is_store;
    logic                  is_lui;
    logic                  is_auipc;
    logic                  writes_rd;
    logic                  illegal;
    logic                  pred_taken;
  } uop_t;

  // Number of consecutive set bits starting at lane 0.
  function automatic logic [1:0] leading_ones3(input logic [2:0] v);
    logic [1:0] n;
    if (!v[0])      n = 2'd0;
    else if (!v[1]) n = 2'd1;
    else if (!v[2]) n = 2'd2;
    else            n = 2'd3;
    return n;
  endfunction

  // Lane mask with the lowest n lanes set.
  function automatic logic [2:0] thermometer3(input logic [1:0] n);
    logic [2:0] t;
    case (n)
      2'd0:    t = 3'b000;
      2'd1:    t = 3'b001;
      2'd2:    t = 3'b011;
      default: t = 3'b111;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/rv32i_field_decoder.sv
// Purely combinational single-instruction RV32I field splitter and classifier.
module rv32i_field_decoder
  import decode_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] instruction_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic                  pred_taken_i,
  output uop_t                  uop_o
);

  uop_t decodedUop;
  logic [6:0] opcode;
  logic unusedInstrBits;

  assign opcode = instruction_i[6:0];

  // funct7 only matters through bit 30; the rest is carried by the immediate.
  assign unusedInstrBits = ^{instruction_i[31], instruction_i[29:25]};

  // Extract register/function fields and raise exactly one class flag or illegal.
  always_comb begin
    decodedUop            = '0;
    decodedUop.pc         = pc_i;
    decodedUop.imm        = imm_i;
    decodedUop.pred_taken = pred_taken_i;
    decodedUop.opcode     = opcode;
    decodedUop.rd         = instruction_i[11:7];
    decodedUop.funct3     = instruction_i[14:12];
    decodedUop.rs1        = instruction_i[19:15];
    decodedUop.rs2        = instruction_i[24:20];
    decodedUop.funct7b5   = instruction_i[30];
    case (opcode)
      OPC_OP, OPC_OP_IMM: decodedUop.is_alu    = 1'b1;
      OPC_BRANCH:         decodedUop.is_branch = 1'b1;
      OPC_JAL:            decodedUop.is_jal    = 1'b1;
      OPC_JALR:           decodedUop.is_jalr   = 1'b1;
      OPC_LOAD:           decodedUop.is_load   = 1'b1;
      OPC_STORE:          decodedUop.is_store  = 1'b1;
      OPC_LUI:            decodedUop.is_lui    = 1'b1;
      OPC_AUIPC:          decodedUop.is_auipc  = 1'b1;
      default:            decodedUop.illegal   = 1'b1;
    endcase
    decodedUop.writes_rd = (instruction_i[11:7] != 5'd0) &&
                           !decodedUop.is_branch && !decodedUop.is_store;
  end

  assign uop_o = decodedUop;

endmodule

// File: rtl/multi_decode_stage.sv
// 3-wide decode stage: per-lane decode into a 3-entry compacting micro-op queue.
module multi_decode_stage
  import decode_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [2:0]            decode_valid_i,
  input  logic [DATA_WIDTH-1:0] instruction_i_0,
  input  logic [DATA_WIDTH-1:0] instruction_i_1,
  input  logic [DATA_WIDTH-1:0] instruction_i_2,
  input  logic [DATA_WIDTH-1:0] pc_i_0,
  input  logic [DATA_WIDTH-1:0] pc_i_1,
  input  logic [DATA_WIDTH-1:0] pc_i_2,
  input  logic [DATA_WIDTH-1:0] imm_i_0,
  input  logic [DATA_WIDTH-1:0] imm_i_1,
  input  logic [DATA_WIDTH-1:0] imm_i_2,
  input  logic                  branch_prediction_i_0,
  input  logic                  branch_prediction_i_1,
  input  logic                  branch_prediction_i_2,
  output logic [2:0]            decode_ready_o,
  output logic [2:0]            issue_valid_o,
  output uop_t                  uop_o_0,
  output uop_t                  uop_o_1,
  output uop_t                  uop_o_2,
  input  logic [2:0]            issue_ready_i,
  output logic [1:0]            occupancy_o
);

  uop_t       decodedUop [LANES];
  uop_t       slots_q    [LANES];
  uop_t       slots_d    [LANES];
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
  logic [1:0] acceptCount;
  logic [1:0] consumeCount;
  logic [2:0] keepCount;
  logic [2:0] fillEnd;
  logic [1:0] srcIdx;
  logic [1:0] laneIdx;

  rv32i_field_decoder u_dec0 (
    .instruction_i (instruction_i_0),
    .pc_i          (pc_i_0),
    .imm_i         (imm_i_0),
    .pred_taken_i  (branch_prediction_i_0),
    .uop_o         (decodedUop[0])
  );

  rv32i_field_decoder u_dec1 (
    .instruction_i (instruction_i_1),
    .pc_i          (pc_i_1),
    .imm_i         (imm_i_1),
    .pred_taken_i  (branch_prediction_i_1),
    .uop_o         (decodedUop[1])
  );

  rv32i_field_decoder u_dec2 (
    .instruction_i (instruction_i_2),
    .pc_i          (pc_i_2),
    .imm_i         (imm_i_2),
    .pred_taken_i  (branch_prediction_i_2),
    .uop_o         (decodedUop[2])
  );

  // Handshakes come from the registered count only, so ready never depends on issue_ready_i.
  assign decode_ready_o = thermometer3(2'd3 - cnt_q);
  assign issue_valid_o  = thermometer3(cnt_q);
  assign acceptCount    = leading_ones3(decode_valid_i & decode_ready_o);
  assign consumeCount   = leading_ones3(issue_valid_o & issue_ready_i);
  assign keepCount      = {1'b0, cnt_q} - {1'b0, consumeCount};
  assign fillEnd        = keepCount + {1'b0, acceptCount};

  // Shift out consumed entries, compact survivors to slot 0, append accepted lanes behind them.
  always_comb begin
    slots_d = '{default: '0};
    cnt_d   = cnt_q;
    srcIdx  = '0;
    laneIdx = '0;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      cnt_d = fillEnd[1:0];
      for (int i = 0; i < LANES; i++) begin
        srcIdx  = 2'(i) + consumeCount;
        laneIdx = 2'(i) - keepCount[1:0];
        if (3'(i) < keepCount) begin
          slots_d[i] = slots_q[srcIdx];
        end else if (3'(i) < fillEnd) begin
          slots_d[i] = decodedUop[laneIdx];
        end
      end
    end
  end

  // Queue state register; reset clears every slot so idle outputs read as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= 2'd0;
      slots_q <= '{default: '0};
    end else begin
      cnt_q   <= cnt_d;
      slots_q <= slots_d;
    end
  end

  assign uop_o_0     = slots_q[0];
  assign uop_o_1     = slots_q[1];
  assign uop_o_2     = slots_q[2];
  assign occupancy_o = cnt_q;

endmodule

// File: tb/tb_multi_decode_stage.sv
// Scoreboard bench for multi_decode_stage: directed scenarios followed by random traffic.
module tb_multi_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [2:0]  decode_valid_i;
  logic [2:0]  issue_ready_i;
  logic [31:0] instrV [3];
  logic [31:0] pcV    [3];
  logic [31:0] immV   [3];
  logic        predV  [3];
  logic [2:0]  decode_ready_o;
  logic [2:0]  issue_valid_o;
  uop_t        uop_o_0;
  uop_t        uop_o_1;
  uop_t        uop_o_2;
  logic [1:0]  occupancy_o;

  int   checkCount = 0;
  int   passCount  = 0;
  uop_t expQ [$];
  int   modelCnt   = 0;
  int   preCnt     = 0;
  logic preFlush   = 1'b0;
  logic preReset   = 1'b1;
  logic [2:0] preReady = 3'b000;
  bit   monitorOn  = 1'b0;

  always #5 clk = ~clk;

  multi_decode_stage dut (
    .clk                   (clk),
    .reset                 (reset),
    .flush                 (flush),
    .decode_valid_i        (decode_valid_i),
    .instruction_i_0       (instrV[0]),
    .instruction_i_1       (instrV[1]),
    .instruction_i_2       (instrV[2]),
    .pc_i_0                (pcV[0]),
    .pc_i_1                (pcV[1]),
    .pc_i_2                (pcV[2]),
    .imm_i_0               (immV[0]),
    .imm_i_1               (immV[1]),
    .imm_i_2               (immV[2]),
    .branch_prediction_i_0 (predV[0]),
    .branch_prediction_i_1 (predV[1]),
    .branch_prediction_i_2 (predV[2]),
    .decode_ready_o        (decode_ready_o),
    .issue_valid_o         (issue_valid_o),
    .uop_o_0               (uop_o_0),
    .uop_o_1               (uop_o_1),
    .uop_o_2               (uop_o_2),
    .issue_ready_i         (issue_ready_i),
    .occupancy_o           (occupancy_o)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int leadOnes(input logic [2:0] v);
    int n = 0;
    while (n < 3 && v[n]) n++;
    return n;
  endfunction

  function automatic logic [2:0] therm(input int n);
    logic [2:0] t = 3'b000;
    for (int i = 0; i < n; i++) t[i] = 1'b1;
    return t;
  endfunction

  // Reference decode straight from the RV32I opcode map.
  function automatic uop_t refDecode(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic [31:0] imm, input logic pred);
    uop_t u = '0;
    u.pc = pc;
    u.imm = imm;
    u.pred_taken = pred;
    u.opcode = ins[6:0];
    u.rd = ins[11:7];
    u.funct3 = ins[14:12];
    u.rs1 = ins[19:15];
    u.rs2 = ins[24:20];
    u.funct7b5 = ins[30];
    case (ins[6:0])
      7'h33, 7'h13: u.is_alu = 1'b1;
      7'h63:        u.is_branch = 1'b1;
      7'h6f:        u.is_jal = 1'b1;
      7'h67:        u.is_jalr = 1'b1;
      7'h03:        u.is_load = 1'b1;
      7'h23:        u.is_store = 1'b1;
      7'h37:        u.is_lui = 1'b1;
      7'h17:        u.is_auipc = 1'b1;
      default:      u.illegal = 1'b1;
    endcase
    u.writes_rd = (ins[11:7] != 5'd0) && (ins[6:0] != 7'h63) && (ins[6:0] != 7'h23);
    return u;
  endfunction

  function automatic uop_t laneUop(input int k);
    if (k == 0) return uop_o_0;
    if (k == 1) return uop_o_1;
    return uop_o_2;
  endfunction

  task automatic setLane(input int k, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] imm, input logic pred);
    instrV[k] = ins;
    pcV[k]    = pc;
    immV[k]   = imm;
    predV[k]  = pred;
  endtask

  // Drive one cycle of inputs at the falling edge and push expected accepted uops.
  task automatic applyStimulus(input logic [2:0] valid, input logic [2:0] ready,
                               input logic fl, input logic rs);
    int a;
    int c;
    decode_valid_i = valid;
    issue_ready_i  = ready;
    flush          = fl;
    reset          = rs;
    preCnt   = modelCnt;
    preFlush = fl;
    preReset = rs;
    preReady = ready;
    if (rs || fl) begin
      expQ.delete();
      modelCnt = 0;
    end else begin
      a = leadOnes(valid);
      if (a > 3 - modelCnt) a = 3 - modelCnt;
      c = leadOnes(ready);
      if (c > modelCnt) c = modelCnt;
      for (int k = 0; k < a; k++) expQ.push_back(refDecode(instrV[k], pcV[k], immV[k], predV[k]));
      modelCnt = modelCnt - c + a;
    end
    @(negedge clk);
  endtask

  // Monitor: compare handshake state and every held uop, then retire consumed entries.
  initial begin
    int c;
    forever begin
      @(negedge clk);
      #2;
      if (monitorOn) begin
        checkOutput("issue_valid", 128'(issue_valid_o), 128'(therm(preCnt)));
        checkOutput("decode_ready", 128'(decode_ready_o), 128'(therm(3 - preCnt)));
        checkOutput("occupancy", 128'(occupancy_o), 128'(preCnt));
        if (!preFlush && !preReset) begin
          c = leadOnes(preReady);
          if (c > preCnt) c = preCnt;
          for (int k = 0; k < preCnt && k < expQ.size(); k++)
            checkOutput($sformatf("uop lane%0d pc %0h", k, expQ[k].pc), 128'(laneUop(k)), 128'(expQ[k]));
          for (int k = 0; k < c && expQ.size() > 0; k++) void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    logic [6:0]  opcList [12];
    logic [31:0] r;
    logic [2:0]  valid;
    logic [2:0]  ready;
    logic        fl;
    opcList = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7f, 7'h00, 7'h12};
    reset = 1'b1;
    flush = 1'b0;
    decode_valid_i = 3'b000;
    issue_ready_i = 3'b000;
    for (int k = 0; k < 3; k++) setLane(k, 32'h0, 32'h0, 32'h0, 1'b0);

    @(negedge clk);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1);
    monitorOn = 1'b1;
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1);
    checkOutput("reset uop0", 128'(uop_o_0), 128'd0);
    checkOutput("reset uop2", 128'(uop_o_2), 128'd0);

    // Three legal instructions accepted together.
    setLane(0, 32'h00100093, 32'h80000000, 32'h1, 1'b0);
    setLane(1, 32'h00208663, 32'h80000004, 32'hc, 1'b1);
    setLane(2, 32'h00300393, 32'h80000008, 32'h3, 1'b0);
    applyStimulus(3'b111, 3'b111, 1'b0, 1'b0);
    checkOutput("tp1 issue_valid", 128'(issue_valid_o), 128'(3'b111));
    checkOutput("tp1 lane0 rd", 128'(uop_o_0.rd), 128'd1);
    checkOutput("tp1 lane0 rs1", 128'(uop_o_0.rs1), 128'd0);
    checkOutput("tp1 lane0 writes_rd", 128'(uop_o_0.writes_rd), 128'd1);
    checkOutput("tp1 lane1 is_branch", 128'(uop_o_1.is_branch), 128'd1);
    checkOutput("tp1 lane1 rs1", 128'(uop_o_1.rs1), 128'd1);
    checkOutput("tp1 lane1 rs2", 128'(uop_o_1.rs2), 128'd2);
    checkOutput("tp1 lane1 writes_rd", 128'(uop_o_1.writes_rd), 128'd0);
    checkOutput("tp1 lane2 rd", 128'(uop_o_2.rd), 128'd7);

    // Full queue, partial consume of one, no accept.
    checkOutput("tp2 decode_ready full", 128'(decode_ready_o), 128'(3'b000));
    setLane(0, 32'h00100093, 32'h90000000, 32'h0, 1'b0);
    setLane(1, 32'h00100093, 32'h90000004, 32'h0, 1'b0);
    setLane(2, 32'h00100093, 32'h90000008, 32'h0, 1'b0);
    applyStimulus(3'b111, 3'b001, 1'b0, 1'b0);
    checkOutput("tp2 occupancy", 128'(occupancy_o), 128'd2);
    checkOutput("tp2 slot0 pc", 128'(uop_o_0.pc), 128'(32'h80000004));
    checkOutput("tp2 slot1 pc", 128'(uop_o_1.pc), 128'(32'h80000008));
    checkOutput("tp2 decode_ready", 128'(decode_ready_o), 128'(3'b001));

    // Consume two while accepting one in the same cycle.
    setLane(0, 32'h00500113, 32'hA0000000, 32'h5, 1'b0);
    setLane(1, 32'h00500113, 32'hA0000004, 32'h5, 1'b0);
    applyStimulus(3'b011, 3'b011, 1'b0, 1'b0);
    checkOutput("tp3 occupancy", 128'(occupancy_o), 128'd1);
    checkOutput("tp3 slot0 pc", 128'(uop_o_0.pc), 128'(32'hA0000000));
    applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);

    // Non-prefix valid: only lane 0 enters.
    setLane(0, 32'h00000517, 32'hB0000000, 32'h0, 1'b1);
    setLane(1, 32'h00000517, 32'hB0000004, 32'h0, 1'b0);
    setLane(2, 32'h00000517, 32'hB0000008, 32'h0, 1'b0);
    applyStimulus(3'b101, 3'b000, 1'b0, 1'b0);
    checkOutput("tp4 occupancy", 128'(occupancy_o), 128'd1);
    checkOutput("tp4 slot0 pc", 128'(uop_o_0.pc), 128'(32'hB0000000));
    setLane(0, 32'h0000a183, 32'hC0000000, 32'h0, 1'b0);
    setLane(1, 32'h0020a023, 32'hC0000004, 32'h0, 1'b0);
    applyStimulus(3'b111, 3'b000, 1'b0, 1'b0);
    checkOutput("tp4 filled occupancy", 128'(occupancy_o), 128'd3);

    // Flush with a full queue and new arrivals.
    setLane(0, 32'h00100093, 32'hDEAD0000, 32'h0, 1'b0);
    setLane(1, 32'h00100093, 32'hDEAD0004, 32'h0, 1'b0);
    setLane(2, 32'h00100093, 32'hDEAD0008, 32'h0, 1'b0);
    applyStimulus(3'b111, 3'b111, 1'b1, 1'b0);
    checkOutput("tp5 issue_valid", 128'(issue_valid_o), 128'(3'b000));
    checkOutput("tp5 occupancy", 128'(occupancy_o), 128'd0);
    checkOutput("tp5 decode_ready", 128'(decode_ready_o), 128'(3'b111));

    // All-zero word is illegal; canonical nop is an ALU op with no writeback.
    setLane(0, 32'h00000000, 32'hE0000000, 32'h0, 1'b0);
    setLane(1, 32'h00000013, 32'hE0000004, 32'h0, 1'b0);
    applyStimulus(3'b011, 3'b000, 1'b0, 1'b0);
    checkOutput("tp6 zero illegal", 128'(uop_o_0.illegal), 128'd1);
    checkOutput("tp6 nop is_alu", 128'(uop_o_1.is_alu), 128'd1);
    checkOutput("tp6 nop writes_rd", 128'(uop_o_1.writes_rd), 128'd0);

    // Random traffic with occasional flush and one mid-run reset.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 3; k++) begin
        r = $urandom();
        if ($urandom_range(0, 5) == 0) r[11:7] = 5'd0;
        setLane(k, {r[31:7], opcList[$urandom_range(0, 11)]}, $urandom(), $urandom(), 1'($urandom_range(0, 1)));
      end
      valid = 3'($urandom_range(0, 7));
      ready = 3'($urandom_range(0, 7));
      fl = ($urandom_range(0, 15) == 0);
      applyStimulus(valid, ready, fl, (n == 200));
    end
    for (int n = 0; n < 4; n++) applyStimulus(3'b000, 3'b111, 1'b0, 1'b0);
    #5;
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
